// File: rtl/rete_ctrl.sv
// rete_ctrl: sequencer for a two-register accumulate datapath.
// Runs LOAD_A, LOAD_B, cnt ALU iterations, then DONE, with abort.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    run request, sampled in IDLE only
//   cnt      iteration count, latched on start
//   op       ALU op for iterations (0 add, 1 sub), latched on start
//   abort    synchronous cancel of a running sequence
//   mux1     A-input select (0 x, 1 ALU)
//   mux2     B-input select (0 y, 1 ALU)
//   wea/web  register A/B write enables
//   aluctl   ALU control (0 add, 1 sub)
//   busy     sequence in progress
//   done     one-cycle completion pulse
module rete_ctrl #(
  parameter int unsigned C = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [C-1:0] cnt,
  input  logic         op,
  input  logic         abort,
  output logic         mux1,
  output logic         mux2,
  output logic         wea,
  output logic         web,
  output logic         aluctl,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ITER,
    DONE
  } state_e;

  localparam logic [C-1:0] ONE = C'(1);

  state_e       state_q, state_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic         op_q, op_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          cnt_d   = cnt;
          op_d    = op;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        if (cnt_q != '0) state_d = ITER;
        else             state_d = DONE;
      end
      ITER: begin
        // ITER is only entered with a nonzero count, so the
        // guard just keeps the counter from ever wrapping.
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        if (cnt_q == ONE || cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over every transition but is meaningless in IDLE,
    // so a start alongside abort in IDLE still launches a run.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      op_d    = 1'b0;
    end
  end

  always_comb begin
    mux1   = 1'b0;
    mux2   = 1'b0;
    wea    = 1'b0;
    web    = 1'b0;
    aluctl = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOAD_A: begin
        busy = 1'b1;
        wea  = 1'b1;
      end
      LOAD_B: begin
        busy = 1'b1;
        web  = 1'b1;
      end
      ITER: begin
        busy   = 1'b1;
        web    = 1'b1;
        mux2   = 1'b1;
        aluctl = op_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rete_ctrl.sv
// tb_rete_ctrl: directed plus random bench for rete_ctrl with a
// cycle-sequence model and a behavioural accumulate datapath.
module tb_rete_ctrl;

  localparam int C = 4;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [C-1:0] cnt     = '0;
  logic         op      = 1'b0;
  logic         abort   = 1'b0;
  logic         mux1, mux2, wea, web, aluctl, busy, done;

  rete_ctrl #(.C(C)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .cnt     (cnt),
    .op      (op),
    .abort   (abort),
    .mux1    (mux1),
    .mux2    (mux2),
    .wea     (wea),
    .web     (web),
    .aluctl  (aluctl),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] x_v = 8'd8;
  logic [7:0] y_v = 8'd7;
  logic [7:0] dp_a, dp_b, alu;

  assign alu = aluctl ? dp_a - dp_b : dp_a + dp_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dp_a <= '0;
      dp_b <= '0;
    end else begin
      if (wea) dp_a <= mux1 ? alu : x_v;
      if (web) dp_b <= mux2 ? alu : y_v;
    end
  end

  // Expected outputs per cycle: {busy,done,mux1,mux2,wea,web,aluctl}.
  logic [6:0] exp_q[$];
  logic [7:0] exp_b;

  function automatic logic [7:0] ref_b(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input int n,
                                       input logic o);
    logic [7:0] b;
    b = y;
    for (int i = 0; i < n; i++) b = o ? x - b : x + b;
    return b;
  endfunction

  function automatic logic [6:0] outs();
    return {busy, done, mux1, mux2, wea, web, aluctl};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_run(input int n, input logic o);
    exp_q.push_back(7'b1000100);
    exp_q.push_back(7'b1000010);
    for (int i = 0; i < n; i++) exp_q.push_back({6'b100101, o});
    exp_q.push_back(7'b1100000);
  endtask

  task automatic step(input logic s, input logic [C-1:0] c,
                      input logic o, input logic a,
                      input string tag);
    logic [6:0] e;
    start = s;
    cnt   = c;
    op    = o;
    abort = a;
    @(posedge clock);
    if (exp_q.size() != 0) begin
      if (a) exp_q.delete();
      else   void'(exp_q.pop_front());
    end else if (s) begin
      push_run(int'(c), o);
      exp_b = ref_b(x_v, y_v, int'(c), o);
    end
    #1;
    e = (exp_q.size() != 0) ? exp_q[0] : 7'd0;
    chk(tag, {1'b0, outs()}, {1'b0, e});
    if (e[5]) chk({tag, "_b"}, dp_b, exp_b);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #2;
    chk("rst_async", {1'b0, outs()}, 8'd0);
    @(posedge clock);
    #1;
    chk("rst_edge", {1'b0, outs()}, 8'd0);
    reset_n = 1'b1;

    step(1'b1, 4'd3, 1'b0, 1'b0, "add");
    idle(7, "add");

    step(1'b1, 4'd0, 1'b1, 1'b0, "zero");
    idle(4, "zero");

    step(1'b1, 4'd15, 1'b1, 1'b0, "max");
    idle(19, "max");

    step(1'b1, 4'd5, 1'b0, 1'b0, "busy");
    idle(3, "busy");
    step(1'b1, 4'd9, 1'b1, 1'b0, "busy_st");
    idle(6, "busy");

    step(1'b1, 4'd0, 1'b0, 1'b0, "hold");
    for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 1'b0, 1'b0, "hold");
    idle(5, "hold");

    step(1'b1, 4'd4, 1'b0, 1'b0, "abort");
    idle(3, "abort");
    step(1'b0, '0, 1'b0, 1'b1, "abort_hit");
    idle(2, "abort");
    step(1'b0, '0, 1'b0, 1'b1, "abort_idle");
    step(1'b1, 4'd2, 1'b0, 1'b1, "abort_st");
    idle(6, "abort");

    step(1'b1, 4'd2, 1'b0, 1'b0, "areset");
    step(1'b0, '0, 1'b0, 1'b0, "areset");
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_mid", {1'b0, outs()}, 8'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    chk("areset_held", {1'b0, outs()}, 8'd0);
    reset_n = 1'b1;
    step(1'b1, 4'd1, 1'b1, 1'b0, "rel_start");
    idle(6, "rel");

    x_v = 8'($urandom);
    y_v = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      logic s, o, a;
      logic [C-1:0] c;
      s = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 5) == 0) ? 4'd15 : C'($urandom);
      o = 1'($urandom);
      a = ($urandom_range(0, 24) == 0);
      step(s, c, o, a, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rete_ctrl.md
RETE_CTRL -- requirements
Module: rete_ctrl

Interface
REQ-001 Parameter C, default 4: iteration-count width in bits; legal range 1..8.
REQ-002 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous active-low reset.
REQ-004 Port start, input, 1: request to run one sequence; sampled only in IDLE.
REQ-005 Port cnt, input, C: number of accumulate iterations; latched when start is accepted.
REQ-006 Port op, input, 1: ALU operation for the iterations, 0=add, 1=subtract; latched when start is accepted.
REQ-007 Port abort, input, 1: synchronous cancel of a running sequence.
REQ-008 Port mux1, output, 1: datapath A-input select, 0=external x, 1=ALU result.
REQ-009 Port mux2, output, 1: datapath B-input select, 0=external y, 1=ALU result.
REQ-010 Port wea, output, 1: datapath register A write enable.
REQ-011 Port web, output, 1: datapath register B write enable.
REQ-012 Port aluctl, output, 1: datapath ALU control, 0=add, 1=subtract.
REQ-013 Port busy, output, 1: high while a sequence is in progress.
REQ-014 Port done, output, 1: one-cycle pulse on normal completion.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD_A, LOAD_B, ITER, DONE.
REQ-016 All outputs SHALL be Moore outputs decoded from registered state; they SHALL not depend combinationally on any input.
REQ-017 IDLE: all outputs low; start=1 at an edge latches cnt into a C-bit down-counter and latches op; next state is LOAD_A.
REQ-018 LOAD_A, one cycle: wea=1, mux1=0, web=0; next state is LOAD_B.
REQ-019 LOAD_B, one cycle: web=1, mux2=0, wea=0; next state is ITER if the latched cnt is nonzero, otherwise DONE.
REQ-020 ITER, one cycle per iteration: web=1, mux2=1, aluctl=latched op, wea=0; each cycle SHALL perform B <= A op B and decrement the counter.
REQ-021 ITER SHALL exit to DONE on the edge where the counter decrements to 0, giving exactly cnt ITER cycles.
REQ-022 DONE, one cycle: done=1, all write enables low; next state is IDLE.
REQ-023 busy SHALL be 1 in LOAD_A, LOAD_B, ITER and DONE, and 0 in IDLE.
REQ-024 In LOAD_A, LOAD_B and DONE, aluctl SHALL be 0; mux1 and mux2 SHALL be 0 wherever not specified above.
REQ-025 Latency from the start-accepting edge to the done pulse SHALL be cnt+3 cycles; the total sequence is cnt+3 cycles.
REQ-026 start asserted while busy=1 SHALL be ignored and not queued; start held high through DONE is accepted on the first IDLE edge.
REQ-027 Changes on cnt or op while busy=1 SHALL have no effect on the running sequence.
REQ-028 abort=1 at an edge in any non-IDLE state SHALL force IDLE on that edge; done SHALL not pulse and outputs SHALL be low in the following cycle.
REQ-029 abort=1 in IDLE SHALL be ignored.
REQ-030 abort and start both high in IDLE SHALL start a sequence, because abort is ignored in IDLE.
REQ-031 cnt = 2^C-1 SHALL run the full count with no wrap; the counter SHALL never decrement below 0.

Reset
REQ-032 reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, clear the counter and latched op, and drive all outputs to 0.
REQ-033 Reset asserted mid-sequence SHALL produce no done pulse; after release, the first start is accepted normally.
REQ-034 Release of reset_n SHALL take effect at the next clock edge; start high on that edge is accepted.

Verification
REQ-035 Basic add: reset, then cnt=3, op=0, start pulse -> cycle 1 wea=1,mux1=0; cycle 2 web=1,mux2=0; cycles 3-5 web=1,mux2=1,aluctl=0; cycle 6 done=1; with datapath x=8, y=7, B ends at 31.
REQ-036 Zero count: cnt=0, op=1 -> LOAD_A, LOAD_B, DONE; done in cycle 3; aluctl never high; B=7.
REQ-037 Subtract at max count: C=4, cnt=15, op=1 -> 15 ITER cycles with aluctl=1; done at cycle 18; busy high for 18 cycles.
REQ-038 Busy start: second start pulse during ITER with cnt=5 -> ignored; exactly one done pulse; latched cnt unchanged.
REQ-039 Abort: abort=1 on the 2nd ITER cycle of a cnt=4 run -> next cycle IDLE; all outputs 0; no done pulse; a subsequent start runs normally.
REQ-040 Async reset: reset_n low mid-LOAD_B, between clock edges -> outputs 0 before the next edge; no done pulse after release.
